cp0_tlb_regs: RTL

CP0 register slice holding the TLB-management registers (Index, Random, EntryLo0, EntryLo1, Context, PageMask, Wired, BadVAddr, EntryHi).
- Sits directly upstream of the MMU and drives its `*_in` CP0 ports.
- Captures the MMU's TLBP/TLBR results back into architectural state.
- Services MTC0/MFC0 and records faulting addresses on TLB and address exceptions at commit.

---
 rtl/cp0_tlb_regs.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB-management register slice: Index, Random, EntryLo0/1, Context, PageMask,
// Wired, BadVAddr and EntryHi, feeding the MMU and capturing its TLBP/TLBR results.
module cp0_tlb_regs #(
  parameter int TLB_LINE  = 32,
  parameter int TLB_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_rdata,
  input  logic        tlbp,
  input  logic        tlbr,
  input  logic        tlbwi,
  input  logic        tlbwr,
  input  logic [31:0] tlbp_index,
  input  logic [31:0] tlbr_pagemask,
  input  logic [31:0] tlbr_entrylo0,
  input  logic [31:0] tlbr_entrylo1,
  input  logic [31:0] tlbr_entryhi,
  input  logic        exc_tlb,
  input  logic        addr_exc,
  input  logic [31:0] exc_badvaddr,
  output logic [31:0] index_o,
  output logic [31:0] random_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o,
  output logic [31:0] entryhi_o,
  output logic [31:0] pagemask_o
);
  localparam logic [TLB_WIDTH-1:0] RAND_TOP = TLB_WIDTH'(TLB_LINE - 1);
  localparam logic [4:0] REG_INDEX    = 5'd0;
  localparam logic [4:0] REG_RANDOM   = 5'd1;
  localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
  localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
  localparam logic [4:0] REG_CONTEXT  = 5'd4;
  localparam logic [4:0] REG_PAGEMASK = 5'd5;
  localparam logic [4:0] REG_WIRED    = 5'd6;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_ENTRYHI  = 5'd10;

  logic                 index_p;
  logic [TLB_WIDTH-1:0] index_idx;
  logic [TLB_WIDTH-1:0] random_r;
  logic [TLB_WIDTH-1:0] random_nxt;
  logic [TLB_WIDTH-1:0] wired_r;
  logic [25:0]          entrylo0_r;
  logic [25:0]          entrylo1_r;
  logic [8:0]           ctx_base;
  logic [18:0]          ctx_badvpn2;
  logic [15:0]          pagemask_r;
  logic [31:0]          badvaddr_r;
  logic [18:0]          entryhi_vpn2;
  logic [7:0]           entryhi_asid;

  logic exc_any, tlb_op, do_tlbp, do_tlbr, do_mtc0;
  logic wr_index, wr_lo0, wr_lo1, wr_ctx, wr_pagemask, wr_wired, wr_entryhi;
  logic [31:0] context_val, wired_val;
  logic unused_ok;

  // A committing exception flushes its instruction, so it masks TLB ops and MTC0;
  // a TLB instruction in turn masks a concurrent MTC0.
  assign exc_any = exc_tlb | addr_exc;
  assign tlb_op  = tlbp | tlbr | tlbwi | tlbwr;
  assign do_tlbp = tlbp & ~exc_any;
  assign do_tlbr = tlbr & ~exc_any;
  assign do_mtc0 = mtc0_we & (mtc0_sel == 3'd0) & ~exc_any & ~tlb_op;

  assign wr_index    = do_mtc0 & (mtc0_addr == REG_INDEX);
  assign wr_lo0      = do_mtc0 & (mtc0_addr == REG_ENTRYLO0);
  assign wr_lo1      = do_mtc0 & (mtc0_addr == REG_ENTRYLO1);
  assign wr_ctx      = do_mtc0 & (mtc0_addr == REG_CONTEXT);
  assign wr_pagemask = do_mtc0 & (mtc0_addr == REG_PAGEMASK);
  assign wr_wired    = do_mtc0 & (mtc0_addr == REG_WIRED);
  assign wr_entryhi  = do_mtc0 & (mtc0_addr == REG_ENTRYHI);

  // Random counts down through the non-wired entries and wraps to the top.
  always_comb begin
    random_nxt = random_r - 1'b1;
    if (wr_wired || wired_r >= RAND_TOP || random_r <= wired_r) random_nxt = RAND_TOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_p      <= 1'b0;
      index_idx    <= '0;
      random_r     <= RAND_TOP;
      wired_r      <= '0;
      entrylo0_r   <= '0;
      entrylo1_r   <= '0;
      ctx_base     <= '0;
      ctx_badvpn2  <= '0;
      pagemask_r   <= '0;
      badvaddr_r   <= '0;
      entryhi_vpn2 <= '0;
      entryhi_asid <= '0;
    end else begin
      random_r <= random_nxt;
      if (exc_any) badvaddr_r <= exc_badvaddr;
      if (exc_tlb) begin
        entryhi_vpn2 <= exc_badvaddr[31:13];
        ctx_badvpn2  <= exc_badvaddr[31:13];
      end
      if (do_tlbp) begin
        index_p   <= tlbp_index[31];
        index_idx <= tlbp_index[TLB_WIDTH-1:0];
      end
      if (do_tlbr) begin
        pagemask_r   <= tlbr_pagemask[28:13];
        entrylo0_r   <= tlbr_entrylo0[25:0];
        entrylo1_r   <= tlbr_entrylo1[25:0];
        entryhi_vpn2 <= tlbr_entryhi[31:13];
        entryhi_asid <= tlbr_entryhi[7:0];
      end
      if (wr_index)    index_idx  <= mtc0_wdata[TLB_WIDTH-1:0];
      if (wr_lo0)      entrylo0_r <= mtc0_wdata[25:0];
      if (wr_lo1)      entrylo1_r <= mtc0_wdata[25:0];
      if (wr_ctx)      ctx_base   <= mtc0_wdata[31:23];
      if (wr_pagemask) pagemask_r <= mtc0_wdata[28:13];
      if (wr_wired)    wired_r    <= mtc0_wdata[TLB_WIDTH-1:0];
      if (wr_entryhi) begin
        entryhi_vpn2 <= mtc0_wdata[31:13];
        entryhi_asid <= mtc0_wdata[7:0];
      end
    end
  end

  always_comb begin
    index_o                  = '0;
    index_o[31]              = index_p;
    index_o[TLB_WIDTH-1:0]   = index_idx;
    random_o                 = '0;
    random_o[TLB_WIDTH-1:0]  = random_r;
    wired_val                = '0;
    wired_val[TLB_WIDTH-1:0] = wired_r;
  end

  assign entrylo0_o  = {6'b0, entrylo0_r};
  assign entrylo1_o  = {6'b0, entrylo1_r};
  assign entryhi_o   = {entryhi_vpn2, 5'b0, entryhi_asid};
  assign pagemask_o  = {3'b0, pagemask_r, 13'b0};
  assign context_val = {ctx_base, ctx_badvpn2, 4'b0};

  always_comb begin
    mfc0_rdata = '0;
    if (mfc0_sel == 3'd0) begin
      case (mfc0_addr)
        REG_INDEX:    mfc0_rdata = index_o;
        REG_RANDOM:   mfc0_rdata = random_o;
        REG_ENTRYLO0: mfc0_rdata = entrylo0_o;
        REG_ENTRYLO1: mfc0_rdata = entrylo1_o;
        REG_CONTEXT:  mfc0_rdata = context_val;
        REG_PAGEMASK: mfc0_rdata = pagemask_o;
        REG_WIRED:    mfc0_rdata = wired_val;
        REG_BADVADDR: mfc0_rdata = badvaddr_r;
        REG_ENTRYHI:  mfc0_rdata = entryhi_o;
        default:      mfc0_rdata = '0;
      endcase
    end
  end

  assign unused_ok = ^{mtc0_wdata, tlbp_index, tlbr_pagemask, tlbr_entrylo0,
                       tlbr_entrylo1, tlbr_entryhi, exc_badvaddr};
endmodule
